// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch + data) in front of a single-port memory bus.
// Data has priority; a starvation counter forces a fetch grant, and a watchdog aborts stuck grants.
module mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_addr_i,
  output logic [XLEN-1:0]   if_rdata_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  input  logic [XLEN/8-1:0] mem_wstrb_i,
  output logic [XLEN-1:0]   mem_rdata_o,
  output logic              mem_ack_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [XLEN-1:0]   bus_addr_o,
  output logic [XLEN-1:0]   bus_wdata_o,
  output logic [XLEN/8-1:0] bus_wstrb_o,
  input  logic [XLEN-1:0]   bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              err_o
);

  localparam int SW = XLEN / 8;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM, RESP} state_t;

  state_t          state, state_nxt;
  logic            owner_if;
  logic            we_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [TW-1:0]   tmo_cnt;
  logic [CW-1:0]   starve_cnt;
  logic            err_q;
  logic            any_req, pick_if, in_gnt, tmo_hit;

  assign any_req = if_req_i | mem_req_i;
  assign pick_if = if_req_i & (~mem_req_i | (starve_cnt == CW'(STARVE_MAX)));
  assign in_gnt  = (state == GNT_IF) | (state == GNT_MEM);
  // A bus ack in the final watchdog cycle still completes normally.
  assign tmo_hit = in_gnt & ~bus_ack_i & (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:            if (any_req) state_nxt = pick_if ? GNT_IF : GNT_MEM;
      GNT_IF, GNT_MEM: if (bus_ack_i || tmo_hit) state_nxt = RESP;
      RESP:            state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_if    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      tmo_cnt     <= '0;
      starve_cnt  <= '0;
      err_q       <= 1'b0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          tmo_cnt  <= '0;
          err_q    <= 1'b0;
          owner_if <= pick_if;
          if (pick_if) begin
            addr_q     <= if_addr_i;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            starve_cnt <= '0;
          end else begin
            addr_q  <= mem_addr_i;
            we_q    <= mem_we_i;
            wdata_q <= mem_wdata_i;
            wstrb_q <= mem_wstrb_i;
            if (if_req_i && starve_cnt != CW'(STARVE_MAX))
              starve_cnt <= starve_cnt + CW'(1);
          end
        end
        GNT_IF, GNT_MEM: begin
          if (bus_ack_i) begin
            if (state == GNT_IF) if_rdata_o  <= bus_rdata_i;
            else                 mem_rdata_o <= bus_rdata_i;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            if (state == GNT_IF) if_rdata_o  <= '0;
            else                 mem_rdata_o <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Bus fields come only from the latched copy, so requester changes mid-grant are invisible.
  assign bus_req_o   = in_gnt;
  assign bus_we_o    = (state == GNT_MEM) & we_q;
  assign bus_addr_o  = in_gnt ? addr_q : '0;
  assign bus_wdata_o = (state == GNT_MEM) ? wdata_q : '0;
  assign bus_wstrb_o = (state == GNT_MEM) ? wstrb_q : '0;

  assign if_ack_o  = (state == RESP) &  owner_if;
  assign mem_ack_o = (state == RESP) & ~owner_if;
  assign err_o     = (state == RESP) &  err_q;

endmodule
